// File: rtl/alu_exec_stage.sv
// Two-stage pipelined execute unit: add / sub / increment with flags.
// Stage 1 captures operands, stage 2 holds the registered result.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             err_sticky,
  output logic [15:0]      op_count
);

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_INC = 3'b010;

  typedef struct packed {
    logic             valid;
    logic [2:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s2_t alu;

  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic s2_free;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  logic [WIDTH:0] sum_add;
  logic [WIDTH:0] sum_sub;
  logic [WIDTH:0] sum_inc;

  assign s2_free  = !s2_q.valid || out_ready;
  assign s1_adv   = s1_q.valid && s2_free;
  assign in_ready = !s1_q.valid || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_q.valid && out_ready;

  assign sum_add = {1'b0, s1_q.a} + {1'b0, s1_q.b};
  assign sum_sub = {1'b0, s1_q.a} + {1'b0, ~s1_q.b}
                 + {{WIDTH{1'b0}}, 1'b1};
  assign sum_inc = {1'b0, s1_q.a} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu       = '0;
    alu.valid = 1'b1;
    alu.tag   = s1_q.tag;
    case (s1_q.sel)
      SEL_ADD: begin
        alu.res   = sum_add[WIDTH-1:0];
        alu.carry = sum_add[WIDTH];
        alu.ovf   = (s1_q.a[WIDTH-1] == s1_q.b[WIDTH-1])
                 && (sum_add[WIDTH-1] != s1_q.a[WIDTH-1]);
      end
      SEL_SUB: begin
        alu.res   = sum_sub[WIDTH-1:0];
        alu.carry = sum_sub[WIDTH];
        alu.ovf   = (s1_q.a[WIDTH-1] != s1_q.b[WIDTH-1])
                 && (sum_sub[WIDTH-1] != s1_q.a[WIDTH-1]);
      end
      SEL_INC: begin
        alu.res   = sum_inc[WIDTH-1:0];
        alu.carry = sum_inc[WIDTH];
        // only the largest positive value crosses into negative
        alu.ovf   = !s1_q.a[WIDTH-1] && sum_inc[WIDTH-1];
      end
      default: begin
        alu.ill = 1'b1;
      end
    endcase
    alu.zero = (alu.res == '0);
  end

  always_comb begin
    s1_d = s1_q;
    if (in_fire) begin
      s1_d.valid = 1'b1;
      s1_d.sel   = alu_sel;
      s1_d.a     = op_a;
      s1_d.b     = op_b;
      s1_d.tag   = in_tag;
    end else if (s1_adv) begin
      s1_d.valid = 1'b0;
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (s1_adv) begin
      s2_d = alu;
    end else if (out_fire) begin
      s2_d.valid = 1'b0;
    end
  end

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (out_fire) begin
      if (s2_q.ill) err_d = 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  wire [15:0] op_count_q = cnt_q;

  assign out_valid  = s2_q.valid;
  assign result     = s2_q.res;
  assign zero       = s2_q.zero;
  assign carry      = s2_q.carry;
  assign overflow   = s2_q.ovf;
  assign illegal    = s2_q.ill;
  assign out_tag    = s2_q.tag;
  assign err_sticky = err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        illegal;
  logic [4:0]  out_tag;
  logic        err_sticky;
  logic [15:0] op_count;

  int checks;
  int failures;

  // {out_valid, result, zero, carry, overflow, illegal, out_tag}
  logic [41:0] obs;
  logic [41:0] exp_v;

  alu_exec_stage #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .illegal(illegal),
    .out_tag(out_tag), .err_sticky(err_sticky),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {out_valid, result, zero, carry,
                overflow, illegal, out_tag};

  task automatic drive(input logic [2:0] s,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] t);
    in_valid = 1'b1;
    alu_sel  = s;
    op_a     = a;
    op_b     = b;
    in_tag   = t;
  endtask

  // Issue one op; returns at the negedge where the result is visible.
  task automatic issue(input logic [2:0] s,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] t);
    drive(s, a, b, t);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_sel = 3'd0;
    op_a = '0;
    op_b = '0;
    in_tag = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== 42'd0) begin
      $display("FAIL reset_outputs got=%h exp=%h", obs, 42'd0);
      failures++;
    end
    checks++;
    if ({in_ready, err_sticky, op_count} !== {1'b1, 1'b0, 16'd0}) begin
      $display("FAIL reset_misc got=%b/%b/%h exp=1/0/0000",
               in_ready, err_sticky, op_count);
      failures++;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    drive(3'b000, 32'd5, 32'd3, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL add_latency got=%b exp=0", out_valid);
      failures++;
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL add_5_3 got=%h exp=%h", obs, exp_v);
      failures++;
    end
    @(negedge clk);
    checks++;
    if ({out_valid, op_count} !== {1'b0, 16'd1}) begin
      $display("FAIL add_count got=%b/%h exp=0/0001",
               out_valid, op_count);
      failures++;
    end
    issue(3'b000, 32'h7FFF_FFFF, 32'h1, 5'd5);
    exp_v = {1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL add_ovf got=%h exp=%h", obs, exp_v);
      failures++;
    end
    @(negedge clk);
    issue(3'b000, 32'hFFFF_FFFF, 32'h2, 5'd6);
    exp_v = {1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL add_carry got=%h exp=%h", obs, exp_v);
      failures++;
    end
    @(negedge clk);
  endtask

  task automatic test_sub;
    issue(3'b001, 32'd5, 32'd5, 5'd1);
    exp_v = {1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL sub_5_5 got=%h exp=%h", obs, exp_v);
      failures++;
    end
    @(negedge clk);
    issue(3'b001, 32'd3, 32'd5, 5'd2);
    exp_v = {1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL sub_3_5 got=%h exp=%h", obs, exp_v);
      failures++;
    end
    @(negedge clk);
    issue(3'b001, 32'h8000_0000, 32'h1, 5'd3);
    exp_v = {1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL sub_ovf got=%h exp=%h", obs, exp_v);
      failures++;
    end
    @(negedge clk);
  endtask

  task automatic test_inc;
    issue(3'b010, 32'h7FFF_FFFF, 32'h1234, 5'd8);
    exp_v = {1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL inc_max_pos got=%h exp=%h", obs, exp_v);
      failures++;
    end
    @(negedge clk);
    issue(3'b010, 32'hFFFF_FFFF, 32'h5, 5'd9);
    exp_v = {1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL inc_all_ones got=%h exp=%h", obs, exp_v);
      failures++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [4:0]  got [8];
    int          n;
    logic        acc;
    logic [15:0] cnt0;
    n = 0;
    cnt0 = op_count;
    out_ready = 1'b1;
    drive(3'b000, 32'd10, 32'd1, 5'd1);
    @(negedge clk);
    drive(3'b000, 32'd20, 32'd2, 5'd2);
    @(negedge clk);
    checks++;
    if ({out_valid, out_tag, result} !== {1'b1, 5'd1, 32'd11}) begin
      $display("FAIL b2b_first got=%b/%0d/%h exp=1/1/0000000b",
               out_valid, out_tag, result);
      failures++;
    end
    out_ready = 1'b0;
    drive(3'b000, 32'd30, 32'd3, 5'd3);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL b2b_full got=%b exp=0", in_ready);
      failures++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({out_valid, out_tag, result, in_ready}
          !== {1'b1, 5'd1, 32'd11, 1'b0}) begin
        $display("FAIL b2b_hold%0d got=%b/%0d/%h/%b exp=1/1/0000000b/0",
                 i, out_valid, out_tag, result, in_ready);
        failures++;
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid && out_ready && n < 8) begin
        got[n] = out_tag;
        n++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (n !== 3) begin
      $display("FAIL b2b_count got=%0d exp=3", n);
      failures++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (n > k && got[k] !== 5'(k + 1)) begin
        $display("FAIL b2b_order%0d got=%0d exp=%0d", k, got[k], k + 1);
        failures++;
      end
    end
    checks++;
    if (op_count !== cnt0 + 16'd3) begin
      $display("FAIL b2b_opcount got=%h exp=%h", op_count, cnt0 + 16'd3);
      failures++;
    end
  endtask

  task automatic test_illegal;
    issue(3'b101, 32'h55, 32'hAA, 5'd7);
    exp_v = {1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL illegal_out got=%h exp=%h", obs, exp_v);
      failures++;
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      $display("FAIL illegal_pre_hs got=%b exp=0", err_sticky);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (err_sticky !== 1'b1) begin
      $display("FAIL illegal_sticky got=%b exp=1", err_sticky);
      failures++;
    end
    issue(3'b000, 32'd1, 32'd1, 5'd2);
    @(negedge clk);
    checks++;
    if ({err_sticky, illegal, result} !== {1'b1, 1'b0, 32'd2}) begin
      $display("FAIL illegal_keep got=%b/%b/%h exp=1/0/00000002",
               err_sticky, illegal, result);
      failures++;
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(3'b000, 32'd1, 32'd2, 5'd11);
    @(negedge clk);
    drive(3'b001, 32'd9, 32'd4, 5'd12);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_tag} !== {1'b1, 1'b0, 5'd11}) begin
      $display("FAIL mid_full got=%b/%b/%0d exp=1/0/11",
               out_valid, in_ready, out_tag);
      failures++;
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 42'd0) begin
      $display("FAIL mid_reset_out got=%h exp=%h", obs, 42'd0);
      failures++;
    end
    checks++;
    if ({in_ready, err_sticky, op_count} !== {1'b1, 1'b0, 16'd0}) begin
      $display("FAIL mid_reset_misc got=%b/%b/%h exp=1/0/0000",
               in_ready, err_sticky, op_count);
      failures++;
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL mid_no_residue got=%b exp=0", out_valid);
      failures++;
    end
  endtask

  task automatic test_saturation;
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    issue(3'b000, 32'd4, 32'd4, 5'd1);
    @(negedge clk);
    checks++;
    if (op_count !== 16'hFFFF) begin
      $display("FAIL sat_count got=%h exp=ffff", op_count);
      failures++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_add;
    test_sub;
    test_inc;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    test_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Two-stage pipelined execute unit that consumes the 3-bit ALU select code from the ALU controller and performs the selected operation. It sits between the decode/register-read stage and memory/writeback. Operands and select are captured in stage 1; result and flags are computed and registered in stage 2. A valid/ready handshake on both sides allows the downstream stage to stall the pipe without loss or duplication.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- TAG_W, 5, destination-register tag width carried alongside each operation

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  stage 1 accepts this cycle
- alu_sel  input  3  000 add, 001 sub, 010 increment op_a; 011–111 illegal
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B (ignored for increment)
- in_tag  input  TAG_W  destination tag, passed through unchanged
- out_valid  output  1  stage 2 holds a result
- out_ready  input  1  downstream accepts this cycle
- result  output  WIDTH  registered result
- zero  output  1  result == 0 (used for beq)
- carry  output  1  add/inc: carry-out; sub: no-borrow (op_a >= op_b unsigned)
- overflow  output  1  signed overflow of the selected operation
- illegal  output  1  this result came from an illegal select
- out_tag  output  TAG_W  tag of the result
- err_sticky  output  1  set by any illegal select ever leaving stage 2
- op_count  output  16  number of output handshakes, saturating at 0xFFFF

## Operation
- Stage 1 register S1: s1_valid, sel, a, b, tag. Stage 2 register S2: out_valid plus all result outputs.
- s2_free = !out_valid || out_ready. S1 advances into S2 when s1_valid && s2_free.
- in_ready = !s1_valid || s2_free (combinational, no dependence on in_valid).
- Input handshake: in_valid && in_ready loads S1; otherwise S1 holds if not advancing, clears s1_valid if advancing.
- Output handshake: out_valid && out_ready; if no new S1 data moves in simultaneously, out_valid drops.
- Arithmetic, computed on S1 contents as S1 moves to S2 (WIDTH+1-bit internal sum):
  - add: a + b; carry = bit WIDTH; overflow = a,b same sign and result sign differs.
  - sub: a + ~b + 1; carry = bit WIDTH (1 = no borrow); overflow = a,b differ in sign and result sign differs from a.
  - inc: a + 1; carry = bit WIDTH; overflow = a == 0x7FFF_FFFF (for WIDTH 32).
  - illegal: result 0, carry 0, overflow 0, zero 1, illegal 1.
- Result wraps modulo 2^WIDTH; no saturation.
- err_sticky sets on the output handshake of an illegal result; cleared only by reset.
- op_count increments on each output handshake; holds at 0xFFFF.
- While out_valid && !out_ready, all S2 outputs are held stable.

## Timing
- Reset (async assert, sync release on clk): s1_valid 0, out_valid 0, result 0, zero 0, carry 0, overflow 0, illegal 0, out_tag 0, err_sticky 0, op_count 0; in_ready therefore 1.
- Latency: operation accepted at edge N appears with out_valid at edge N+1 (visible after edge N+1) if unstalled; i.e. two registered stages, one-edge-per-stage.
- Throughput: one op per cycle with out_ready held 1.
- Full: S1 and S2 both valid and out_ready 0 → in_ready 0; upstream must hold inputs.
- Simultaneous output handshake and S1 advance: S2 replaced same edge, out_valid stays 1, no bubble.
- Simultaneous input handshake and S1 advance: S1 replaced same edge.
- Reset asserted mid-operation discards both stages immediately; no partial output.

## Test plan
- Reset then add 0x0000_0005 + 0x0000_0003, out_ready 1 → result 0x8, zero 0, carry 0, overflow 0, out_valid one cycle after S1 load, op_count 1.
- Sub 5 − 5 (beq) → result 0, zero 1, carry 1; sub 3 − 5 → 0xFFFF_FFFE, carry 0.
- Inc 0x7FFF_FFFF → 0x8000_0000, overflow 1; inc 0xFFFF_FFFF → 0, zero 1, carry 1, overflow 0.
- Stream tags 1,2,3 back-to-back, out_ready low 3 cycles after first output → in_ready falls with both stages full, outputs held, then tags 1,2,3 delivered in order, none lost or duplicated.
- alu_sel 101 with tag 7 → result 0, illegal 1, out_tag 7, err_sticky 1 after handshake and remains 1 across subsequent legal ops until reset.
- Assert reset while both stages valid → all outputs return to reset values asynchronously, in_ready 1; op_count saturation checked by forcing 0xFFFF and one more handshake → stays 0xFFFF.
